// File: rtl/ahb_master_arb_if.sv
// rtl/ahb_master_arb_if.sv - Requester-side and AHB master command port bundle for ahb_master_arb
interface ahb_master_arb_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*3-1:0]          req_burst;
  logic [NUM_REQ*3-1:0]          req_size;
  logic [NUM_REQ*4-1:0]          req_prot;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*SW-1:0]         req_strb;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_end_trans;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_error;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  logic                  m_valid;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [2:0]            m_burst;
  logic [2:0]            m_size;
  logic [3:0]            m_prot;
  logic                  m_write;
  logic [SW-1:0]         m_strb;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_end_trans;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_error;

  modport master (
    input  req_valid, req_addr, req_burst, req_size, req_prot, req_write,
           req_strb, req_wdata, req_end_trans,
    output req_ready, req_error, rsp_rdata,
    output m_valid, m_addr, m_burst, m_size, m_prot, m_write, m_strb,
           m_wdata, m_end_trans,
    input  m_ready, m_rdata, m_error
  );

  modport slave (
    output req_valid, req_addr, req_burst, req_size, req_prot, req_write,
           req_strb, req_wdata, req_end_trans,
    input  req_ready, req_error, rsp_rdata,
    input  m_valid, m_addr, m_burst, m_size, m_prot, m_write, m_strb,
           m_wdata, m_end_trans,
    output m_ready, m_rdata, m_error
  );
endinterface

// File: rtl/ahb_master_arb.sv
// rtl/ahb_master_arb.sv - Round-robin owner arbiter for one AHB master command port
// A requester keeps the port from its first beat until its end_trans beat handshakes.
module ahb_master_arb #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ahb_master_arb_if.master     bus,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic                 len_err
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [4:0]      beat_cnt_q, beat_cnt_d;
  logic [2:0]      burst_q, burst_d;
  logic            len_err_q, len_err_d;

  logic [GW-1:0]   winner;
  logic            any_valid;
  logic            own;
  logic            hs;
  int              g_idx;
  logic [2:0]      burst_chk;
  logic [5:0]      total_beats;
  logic [5:0]      exp_beats;
  logic            len_bad;

  function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_REQ;
    return GW'(s);
  endfunction

  // Scan from farthest to nearest so the index closest after last_q is assigned last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req_valid[rr_index(last_q, k)]) begin
        winner    = rr_index(last_q, k);
        any_valid = 1'b1;
      end
    end
  end

  // Reset gates the mux so an aborted transfer stops forwarding in the reset cycle itself.
  assign own   = (state_q == OWN) && !rst;
  assign g_idx = int'(grant_q);

  always_comb begin
    bus.m_valid     = 1'b0;
    bus.m_addr      = '0;
    bus.m_burst     = '0;
    bus.m_size      = '0;
    bus.m_prot      = '0;
    bus.m_write     = 1'b0;
    bus.m_strb      = '0;
    bus.m_wdata     = '0;
    bus.m_end_trans = 1'b0;
    bus.req_ready   = '0;
    bus.req_error   = '0;
    bus.rsp_rdata   = '0;
    if (own) begin
      bus.m_valid          = bus.req_valid[g_idx];
      bus.m_addr           = bus.req_addr[g_idx*ADDR_WIDTH +: ADDR_WIDTH];
      bus.m_burst          = bus.req_burst[g_idx*3 +: 3];
      bus.m_size           = bus.req_size[g_idx*3 +: 3];
      bus.m_prot           = bus.req_prot[g_idx*4 +: 4];
      bus.m_write          = bus.req_write[g_idx];
      bus.m_strb           = bus.req_strb[g_idx*SW +: SW];
      bus.m_wdata          = bus.req_wdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
      bus.m_end_trans      = bus.req_end_trans[g_idx];
      bus.req_ready[g_idx] = bus.m_ready;
      bus.req_error[g_idx] = bus.m_error & bus.m_ready;
      bus.rsp_rdata        = bus.m_rdata;
    end
  end

  assign hs = bus.m_valid & bus.m_ready;

  // The burst code is trusted only from the first beat; later beats may carry anything.
  always_comb begin
    burst_chk   = (beat_cnt_q == 5'd0) ? bus.m_burst : burst_q;
    total_beats = {1'b0, beat_cnt_q} + 6'd1;
    case (burst_chk)
      3'd0:       exp_beats = 6'd1;
      3'd2, 3'd3: exp_beats = 6'd4;
      3'd4, 3'd5: exp_beats = 6'd8;
      3'd6, 3'd7: exp_beats = 6'd16;
      default:    exp_beats = 6'd0;
    endcase
    len_bad = (burst_chk != 3'd1) && (total_beats != exp_beats);
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    burst_d    = burst_q;
    len_err_d  = len_err_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d    = OWN;
          grant_d    = winner;
          last_d     = winner;
          beat_cnt_d = '0;
        end
      end
      OWN: begin
        if (hs) begin
          if (beat_cnt_q == 5'd0) burst_d = bus.m_burst;
          if (beat_cnt_q != 5'd31) beat_cnt_d = beat_cnt_q + 5'd1;
          if (bus.m_end_trans) begin
            state_d = IDLE;
            grant_d = '0;
            if (len_bad) len_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= GW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      burst_q    <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      burst_q    <= burst_d;
      len_err_q  <= len_err_d;
    end
  end

  assign busy     = (state_q == OWN);
  assign grant_id = grant_q;
  assign len_err  = len_err_q;
endmodule

// File: doc/ahb_master_arb.md
Name: ahb_master_arb

Overview:
Round-robin arbiter that shares one AHB master command interface between NUM_REQ testbench/RTL requesters. A requester owns the master port for a whole transfer, from the first beat until the beat tagged end_trans has handshaken. The arbiter routes responses (ready, rdata, error) back to the owner and checks that burst beat counts match the HBURST encoding. It sits between the stimulus/sequencer layer and the single AHB master command port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; strobe width SW = DATA_WIDTH/8
GW, derived = max(1, clog2(NUM_REQ)), grant index width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester beat valid
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_burst  in  NUM_REQ*3  HBURST code
req_size  in  NUM_REQ*3  HSIZE code
req_prot  in  NUM_REQ*4  HPROT
req_write  in  NUM_REQ  1=write
req_strb  in  NUM_REQ*SW  write strobes
req_wdata  in  NUM_REQ*DATA_WIDTH  write data
req_end_trans  in  NUM_REQ  marks last beat of transfer
req_ready  out  NUM_REQ  beat accepted (owner only)
req_error  out  NUM_REQ  error for accepted beat (owner only)
rsp_rdata  out  DATA_WIDTH  read data, valid with the owner's req_ready
m_valid, m_addr, m_burst, m_size, m_prot, m_write, m_strb, m_wdata, m_end_trans  out  1/ADDR_WIDTH/3/3/4/1/SW/DATA_WIDTH/1  muxed command to master port
m_ready  in  1  master accepts beat
m_rdata  in  DATA_WIDTH  master read data
m_error  in  1  master error for current beat
busy  out  1  a requester owns the port
grant_id  out  GW  index of owner (0 when idle)
len_err  out  1  sticky burst-length violation flag

Behaviour:
- Reset values: state IDLE, busy=0, grant_id=0, len_err=0, beat_cnt=0, last_grant=NUM_REQ-1. All m_* outputs, req_ready, req_error and rsp_rdata are 0. Reset mid-burst aborts the transfer immediately; no further beats are forwarded.
- FSM has two states: IDLE and OWN.
- IDLE:
  - If any req_valid is set, the winner is the first set index scanning cyclically from last_grant+1.
  - On that clock edge: grant_id<=winner, last_grant<=winner, beat_cnt<=0, state<=OWN.
  - Arbitration latency is 1 cycle. m_valid is 0 throughout IDLE.
- OWN:
  - m_* is a combinational copy of requester grant_id's fields; m_valid=req_valid[grant_id].
  - req_ready[grant_id]=m_ready. req_error[grant_id]=m_error & m_ready. rsp_rdata=m_rdata. All other req_ready/req_error are 0.
  - Handshake occurs when m_valid & m_ready. Each handshake increments beat_cnt, which is 5 bits and saturates at 31.
  - If the owner drops req_valid mid-transfer, ownership is kept and m_valid=0. There is no timeout.
  - A handshake with m_end_trans=1 sends the state to IDLE on that edge. Re-arbitration therefore happens in the following IDLE cycle, giving exactly one bubble cycle between transfers.
  - m_error does not end ownership; only end_trans does.
- Length check, evaluated on the end_trans handshake using total beats = beat_cnt+1:
  - Expected beats: SINGLE(0)=1; WRAP4/INCR4(2,3)=4; WRAP8/INCR8(4,5)=8; WRAP16/INCR16(6,7)=16.
  - INCR(1) accepts any count.
  - m_burst is sampled on the first beat and held for the check.
  - On mismatch, len_err is set to 1 and stays set until rst.
- busy=1 exactly in OWN.
- Fairness: after requester i finishes, a continuously asserting i loses to any other pending requester.
- req_end_trans and all other fields from non-owners are ignored.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with all req_valid=1 -> busy=0, m_valid=0, req_ready=0, len_err=0, grant_id=0.
2. Single requester: req0 sends SINGLE write addr=0x100, wdata=0xA5A5A5A5, end_trans=1, m_ready=1. Expected: busy rises 1 cycle after req_valid; m_addr=0x100 and req_ready[0]=1 for 1 cycle; back to IDLE next edge; len_err=0.
3. Contention: req0 and req1 both issue INCR4 continuously with m_ready=1. Expected: grant order 0,1,0,1; each owns for 4 beats; 1 idle cycle between transfers; req_ready never set for a non-owner.
4. Backpressure/gap: req1 INCR8 read with m_ready low on beats 2-3 and req_valid low for 2 cycles mid-burst. Expected: owner held and beats not counted while stalled; rsp_rdata tracks m_rdata on each handshake; ends after 8 handshakes with len_err=0.
5. Length error: req0 issues INCR4 with end_trans on beat 3 -> len_err=1 after that edge. A later correct SINGLE leaves len_err=1 (sticky).
6. Error and reset: m_error=1 on beat 2 of an INCR4 -> req_error[0]=1 only on that beat, burst continues to beat 4. A second INCR4 receives rst at beat 2 -> next cycle busy=0, m_valid=0, len_err=0.
